flash_cp_ctrl: RTL

FLASH_CP_CTRL -- requirements
Module: flash_cp_ctrl

---
 rtl/flash_cp_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/flash_cp_ctrl.sv
// flash_cp_ctrl
// Controller for the flash high-voltage charge pump. It drives the pump clock
// (CPCLK) while the VCPHV node ramps, declares the node ready once the
// comparator has stayed high for STB cycles, regulates by gating CPCLK on the
// comparator, and runs a timed discharge when the enable request drops.
//
// Optional feature macro: FLASH_CP_TIMEOUT_EN
//   defined   -> a RAMP timeout counter moves the FSM to ERR after RAMP_TO cycles
//   undefined -> no timeout counter, ERR is unreachable, CPERR is tied to 0
//
// Ports
//   CLK    in   single clock, rising edge
//   RSTB   in   asynchronous active-low reset
//   CPEN   in   pump enable request (level, synchronous to CLK)
//   VCMP   in   comparator output (asynchronous, 1 = node at/above target)
//   CPCLK  out  pump drive clock (registered)
//   VCPRDY out  node regulated and usable (registered)
//   VCPDIS out  discharge switch enable (registered)
//   CPERR  out  ramp timeout flag (registered, or constant 0)
//   state  out  FSM state for debug/checkers: 0 IDLE, 1 RAMP, 2 REG, 3 DISCH, 4 ERR
//
// CPEN is a plain level request, not a handshake: 1 asks for the pump, 0 asks
// for discharge. It is only honoured from IDLE; a drop always wins elsewhere
// except during DISCH, which always runs to completion.
module flash_cp_ctrl #(
  parameter int DIV     = 4,
  parameter int STB     = 8,
  parameter int RAMP_TO = 1024,
  parameter int DIS_CYC = 32
) (
  input  logic       CLK,
  input  logic       RSTB,
  input  logic       CPEN,
  input  logic       VCMP,
  output logic       CPCLK,
  output logic       VCPRDY,
  output logic       VCPDIS,
  output logic       CPERR,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAMP  = 3'd1,
    REG   = 3'd2,
    DISCH = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam int DIV_W = $clog2(DIV);
  localparam int STB_W = $clog2(STB + 1);
  localparam int DIS_W = $clog2(DIS_CYC + 1);

  state_t           st;
  logic             vcmp_m;
  logic             vcmp_s;
  logic [DIV_W-1:0] div_cnt;
  logic [STB_W-1:0] stb_cnt;
  logic [DIS_W-1:0] dis_cnt;
  logic             cpclk_q;
  logic             rdy_q;
  logic             dis_q;
  logic             stb_hit;
  logic             div_hit;
  logic             to_hit;

  // Two-flop synchroniser; nothing else looks at VCMP directly.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      vcmp_m <= 1'b0;
      vcmp_s <= 1'b0;
    end else begin
      vcmp_m <= VCMP;
      vcmp_s <= vcmp_m;
    end
  end

  // The stable count "reaches" STB on the cycle that would make it STB,
  // so the FSM leaves RAMP instead of storing STB.
  assign stb_hit = vcmp_s && (stb_cnt == STB_W'(STB - 1));
  assign div_hit = (div_cnt == DIV_W'(DIV - 1));

`ifdef FLASH_CP_TIMEOUT_EN
  localparam int TO_W = $clog2(RAMP_TO + 1);

  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  assign to_hit = (to_cnt == TO_W'(RAMP_TO - 1));

  // Counts cycles spent in RAMP; any exit from RAMP (or any cycle outside it)
  // clears it, so it starts from zero on every RAMP entry.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (st == RAMP && CPEN && !stb_hit && !to_hit) begin
        to_cnt <= to_cnt + TO_W'(1);
      end else begin
        to_cnt <= '0;
      end
      // Set on the RAMP->ERR transition (REG wins a tie), cleared on ERR->DISCH.
      if (st == RAMP && CPEN && !stb_hit && to_hit) begin
        err_q <= 1'b1;
      end else if (st == ERR && !CPEN) begin
        err_q <= 1'b0;
      end
    end
  end

  assign CPERR = err_q;
`else
  assign to_hit = 1'b0;
  assign CPERR  = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      st      <= IDLE;
      div_cnt <= '0;
      stb_cnt <= '0;
      dis_cnt <= '0;
      cpclk_q <= 1'b0;
      rdy_q   <= 1'b0;
      dis_q   <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (CPEN) begin
            st      <= RAMP;
            div_cnt <= '0;
            stb_cnt <= '0;
            cpclk_q <= 1'b0;
          end
        end
        RAMP: begin
          if (!CPEN) begin
            st      <= DISCH;
            dis_q   <= 1'b1;
            rdy_q   <= 1'b0;
            cpclk_q <= 1'b0;
            dis_cnt <= '0;
            div_cnt <= '0;
            stb_cnt <= '0;
          end else if (stb_hit) begin
            st      <= REG;
            rdy_q   <= 1'b1;
            cpclk_q <= 1'b0;
            div_cnt <= '0;
            stb_cnt <= '0;
          end else if (to_hit) begin
            st      <= ERR;
            cpclk_q <= 1'b0;
            div_cnt <= '0;
            stb_cnt <= '0;
          end else begin
            if (div_hit) begin
              div_cnt <= '0;
              cpclk_q <= ~cpclk_q;
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
            end
            stb_cnt <= vcmp_s ? stb_cnt + STB_W'(1) : '0;
          end
        end
        REG: begin
          if (!CPEN) begin
            st      <= DISCH;
            dis_q   <= 1'b1;
            rdy_q   <= 1'b0;
            cpclk_q <= 1'b0;
            dis_cnt <= '0;
            div_cnt <= '0;
          end else if (vcmp_s) begin
            // Node at target: park the pump with the divider restarted.
            cpclk_q <= 1'b0;
            div_cnt <= '0;
          end else if (div_hit) begin
            div_cnt <= '0;
            cpclk_q <= ~cpclk_q;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        ERR: begin
          if (!CPEN) begin
            st      <= DISCH;
            dis_q   <= 1'b1;
            cpclk_q <= 1'b0;
            rdy_q   <= 1'b0;
            dis_cnt <= '0;
          end
        end
        DISCH: begin
          if (dis_cnt == DIS_W'(DIS_CYC - 1)) begin
            st      <= IDLE;
            dis_q   <= 1'b0;
            dis_cnt <= '0;
          end else begin
            dis_cnt <= dis_cnt + DIS_W'(1);
          end
        end
        default: begin
          st      <= IDLE;
          cpclk_q <= 1'b0;
          rdy_q   <= 1'b0;
          dis_q   <= 1'b0;
        end
      endcase
    end
  end

  assign CPCLK  = cpclk_q;
  assign VCPRDY = rdy_q;
  assign VCPDIS = dis_q;
  assign state  = st;

endmodule
